cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the N_CDB common-data-bus (completion) slots among N_REQ functional-unit result ports: ALUs, multiplier, branch unit.
- Buffers one result per requester, grants slots in rotating priority, and drives registered CDB tag/data/wr_en to the ROB, RS wakeup and register file.
- Replaces direct FU-to-CDB wiring so that multi-cycle units can complete without colliding.

Parameters:
N_REQ, 4, number of FU result requesters
N_CDB, 2, number of CDB slots per cycle (equals `N_WAY)
CDB_BITS, 6, physical register tag width
XLEN, 32, result data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  branch hazard squash (branch_haz)
fu_valid  in  N_REQ  result presented by FU i
fu_tag  in  N_REQ x CDB_BITS  destination physical tag
fu_data  in  N_REQ x XLEN  result value
fu_wr_en  in  N_REQ  result writes the register file
fu_ready  out  N_REQ  FU i's result is accepted this cycle
cdb_valid  out  N_CDB  slot carries a broadcast
cdb_tag  out  N_CDB x CDB_BITS  broadcast tag
cdb_data  out  N_CDB x XLEN  broadcast data
cdb_wr_en  out  N_CDB  register-file write enable per slot
grant_count  out  $clog2(N_CDB)+1  number of valid slots (registered)

Behaviour:
- State per requester:
  - hold_valid[i], hold_tag/data/wr_en[i] (one-entry holding register).
  - Shared rr_ptr, $clog2(N_REQ) bits.
- Reset (reset low, asynchronous, even mid-operation): hold_valid=0, rr_ptr=0, cdb_valid/tag/data/wr_en=0, grant_count=0. fu_ready is then all 1.
- Handshake:
  - fu_ready[i] = !hold_valid[i] || grant[i]. Combinational from state only; no dependence on fu_valid.
  - Capture at the clock edge when fu_valid[i] && fu_ready[i] && fu_tag[i]!=0.
  - fu_valid with fu_tag==0 is ignored: nothing is held or broadcast.
  - An FU holds its inputs stable while fu_valid && !fu_ready.
- Arbitration (combinational, on held entries only):
  - Scan requesters rr_ptr, rr_ptr+1, ... mod N_REQ.
  - The first N_CDB with hold_valid are granted, assigned to cdb slot 0, 1, ... in scan order.
- Output registers:
  - Granted entries load cdb_* at the edge; ungranted slots load cdb_valid=0, tag=0, data=0, wr_en=0.
  - grant_count = number of grants.
- Latency: fu_valid in cycle t → captured at the end of t → earliest cdb_valid in cycle t+2. Throughput is one result per requester per cycle while that requester is granted every cycle.
- Same-cycle grant and new capture on requester i: the hold register is replaced by the new result; no bubble.
- rr_ptr: if ≥1 grant, rr_ptr ← (last granted index + 1) mod N_REQ; otherwise unchanged. Wraps at N_REQ-1 → 0.
- Fairness guarantee: a held entry is granted within ceil(N_REQ/N_CDB) cycles of capture.
- Flush (synchronous):
  - At the edge: all hold_valid←0, cdb_valid←0, grant_count←0; rr_ptr unchanged.
  - Inputs presented in the flush cycle are dropped.
  - fu_ready is all 1 in the cycle after the flush.
- Flush and reset together: reset dominates.
- Duplicate tags from two FUs are not checked; both are broadcast.

Decomposition:
- Shared package (sys_defs): typedef CDB_PACKET {valid, tag[CDB_BITS], data[XLEN], wr_en}; typedef FU_RESULT with the same fields; constants N_CDB=`N_WAY, CDB_BITS, N_FU_REQ.
- One natural sub-module: rr_multi_pick. Purely combinational: inputs req vector and rr_ptr; outputs up to N_CDB one-hot grant vectors plus a per-requester grant mask.
- cdb_arbiter owns all registers.

Test Plan:
- Reset: hold req1 and req3 entries, pull reset low mid-cycle → cdb_valid=00 and grant_count=0 immediately; after release fu_ready=1111 and rr_ptr=0.
- Single request: fu_valid=0100, tag=5, data=0xDEAD, wr_en=1 in cycle t → cycle t+2: cdb_valid=01, slot0 tag 5 / data 0xDEAD / wr_en 1, grant_count=1; then rr_ptr=3.
- Full contention: all four valid in cycle t (tags 1-4), rr_ptr=0 → t+1: fu_ready=0011 with grants req0/req1. t+2: slots {tag1, tag2}. t+3: slots {tag3, tag4}. rr_ptr returns to 0.
- Starvation check: req0 presents a new result every cycle with req1-3 held → req0 is not granted a second time before req1, req2 and req3 have each been granted once; all granted within 2 cycles.
- Flush: three entries held, assert flush for one cycle with fu_valid=1000 → next cycle cdb_valid=00, fu_ready=1111, req0 result lost. A request the following cycle completes normally 2 cycles later.
- Tag zero: fu_valid=0010 with tag 0 → never broadcast, fu_ready[1] stays 1, rr_ptr unchanged.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter types and sizing.
// Result and broadcast packets share one layout.
package cdb_arbiter_pkg;

  localparam int N_REQ    = 4;
  localparam int N_FU_REQ = N_REQ;
  localparam int N_CDB    = 2;
  localparam int CDB_BITS = 6;
  localparam int XLEN     = 32;
  localparam int PTR_W    = $clog2(N_REQ);
  localparam int CNT_W    = $clog2(N_CDB) + 1;

  typedef struct packed {
    logic                valid;
    logic [CDB_BITS-1:0] tag;
    logic [XLEN-1:0]     data;
    logic                wr_en;
  } cdb_packet_t;

  typedef struct packed {
    logic                valid;
    logic [CDB_BITS-1:0] tag;
    logic [XLEN-1:0]     data;
    logic                wr_en;
  } fu_result_t;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_pick.sv
// Rotating-priority multi-grant picker.
// Fills CDB slots in scan order starting at rr_ptr.
module rr_multi_pick
  import cdb_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0]            req,
  input  logic [PTR_W-1:0]            rr_ptr,
  output logic [N_CDB-1:0][N_REQ-1:0] slot_gnt,
  output logic [N_REQ-1:0]            gnt_mask
);

  logic [PTR_W-1:0] idx;
  logic [CNT_W-1:0] used;

  always_comb begin
    slot_gnt = '0;
    gnt_mask = '0;
    idx      = rr_ptr;
    used     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req[idx]) begin
        for (int s = 0; s < N_CDB; s++) begin
          if (used == CNT_W'(s)) begin
            slot_gnt[s][idx] = 1'b1;
            gnt_mask[idx]    = 1'b1;
          end
        end
        // Saturate once every slot is taken.
        if (used != CNT_W'(N_CDB)) begin
          used = used + CNT_W'(1);
        end
      end
      idx = ptr_inc(idx);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one hold register per FU result port,
// rotating grants onto N_CDB registered broadcast slots.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [N_REQ-1:0]                fu_valid,
  input  logic [N_REQ-1:0][CDB_BITS-1:0]  fu_tag,
  input  logic [N_REQ-1:0][XLEN-1:0]      fu_data,
  input  logic [N_REQ-1:0]                fu_wr_en,
  output logic [N_REQ-1:0]                fu_ready,
  output logic [N_CDB-1:0]                cdb_valid,
  output logic [N_CDB-1:0][CDB_BITS-1:0]  cdb_tag,
  output logic [N_CDB-1:0][XLEN-1:0]      cdb_data,
  output logic [N_CDB-1:0]                cdb_wr_en,
  output logic [CNT_W-1:0]                grant_count
);

  fu_result_t  [N_REQ-1:0] hold_q, hold_d;
  cdb_packet_t [N_CDB-1:0] cdb_q, cdb_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [N_REQ-1:0]            hold_valid;
  logic [N_REQ-1:0]            cap;
  logic [N_CDB-1:0][N_REQ-1:0] slot_gnt;
  logic [N_REQ-1:0]            gnt_mask;

  rr_multi_pick u_pick (
    .req      (hold_valid),
    .rr_ptr   (rr_ptr_q),
    .slot_gnt (slot_gnt),
    .gnt_mask (gnt_mask)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      hold_valid[i] = hold_q[i].valid;
    end
    fu_ready = ~hold_valid | gnt_mask;
    cap      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cap[i] = fu_valid[i] && fu_ready[i]
            && (fu_tag[i] != '0) && !flush;
    end
  end

  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (flush) begin
        hold_d[i].valid = 1'b0;
      end else if (cap[i]) begin
        hold_d[i] = '{valid: 1'b1,
                      tag:   fu_tag[i],
                      data:  fu_data[i],
                      wr_en: fu_wr_en[i]};
      end else if (gnt_mask[i]) begin
        hold_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    cdb_d    = '0;
    cnt_d    = '0;
    rr_ptr_d = rr_ptr_q;
    if (!flush) begin
      for (int s = 0; s < N_CDB; s++) begin
        for (int i = 0; i < N_REQ; i++) begin
          // Later slots overwrite, leaving the last grant's successor.
          if (slot_gnt[s][i]) begin
            cdb_d[s] = cdb_packet_t'(hold_q[i]);
            rr_ptr_d = ptr_inc(PTR_W'(i));
          end
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        cnt_d = cnt_d + CNT_W'(gnt_mask[i]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q   <= '0;
      cdb_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      hold_q   <= hold_d;
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    for (int s = 0; s < N_CDB; s++) begin
      cdb_valid[s] = cdb_q[s].valid;
      cdb_tag[s]   = cdb_q[s].tag;
      cdb_data[s]  = cdb_q[s].data;
      cdb_wr_en[s] = cdb_q[s].wr_en;
    end
    grant_count = cnt_q;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter.
// Directed stimulus pushes expected broadcasts; a monitor pops them.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [N_REQ-1:0]               fu_valid = '0;
  logic [N_REQ-1:0][CDB_BITS-1:0] fu_tag   = '0;
  logic [N_REQ-1:0][XLEN-1:0]     fu_data  = '0;
  logic [N_REQ-1:0]               fu_wr_en = '0;
  logic [N_REQ-1:0]               fu_ready;
  logic [N_CDB-1:0]               cdb_valid;
  logic [N_CDB-1:0][CDB_BITS-1:0] cdb_tag;
  logic [N_CDB-1:0][XLEN-1:0]     cdb_data;
  logic [N_CDB-1:0]               cdb_wr_en;
  logic [CNT_W-1:0]               grant_count;

  cdb_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .fu_valid    (fu_valid),
    .fu_tag      (fu_tag),
    .fu_data     (fu_data),
    .fu_wr_en    (fu_wr_en),
    .fu_ready    (fu_ready),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_wr_en   (cdb_wr_en),
    .grant_count (grant_count)
  );

  always #5 clock = ~clock;

  int cyc  = 0;
  int nvec = 0;
  int nmis = 0;

  always @(posedge clock) cyc++;

  typedef struct {
    int          cyc;
    logic [1:0]  v;
    logic [5:0]  t0, t1;
    logic [31:0] d0, d1;
    logic [1:0]  we;
    logic [1:0]  cnt;
  } exp_t;

  exp_t q[$];

  task automatic push(input int c, input logic [1:0] v,
                      input logic [5:0] t0, input logic [5:0] t1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] we, input logic [1:0] cnt);
    exp_t e;
    e.cyc = c; e.v = v; e.t0 = t0; e.t1 = t1;
    e.d0 = d0; e.d1 = d1; e.we = we; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fu_valid = '0;
  endtask

  task automatic present(input int i, input logic [5:0] t,
                         input logic [31:0] d, input logic w);
    fu_valid[i] = 1'b1;
    fu_tag[i]   = t;
    fu_data[i]  = d;
    fu_wr_en[i] = w;
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Monitor: every cycle with a broadcast must match the queue head.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (cdb_valid != '0 || grant_count != '0) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          nvec++;
          nmis++;
          $display("FAIL cdb_unexpected cyc=%0d: valid=%b tag0=%0d tag1=%0d",
                   cyc, cdb_valid, cdb_tag[0], cdb_tag[1]);
        end else begin
          e = q.pop_front();
          nvec++;
          if (cdb_valid !== e.v || cdb_tag[0] !== e.t0 ||
              cdb_tag[1] !== e.t1 || cdb_data[0] !== e.d0 ||
              cdb_data[1] !== e.d1 || cdb_wr_en !== e.we ||
              grant_count !== e.cnt) begin
            nmis++;
            $display("FAIL cdb_pkt cyc=%0d: got v=%b t=%0d/%0d d=%h/%h we=%b n=%0d expected v=%b t=%0d/%0d d=%h/%h we=%b n=%0d",
                     cyc, cdb_valid, cdb_tag[0], cdb_tag[1],
                     cdb_data[0], cdb_data[1], cdb_wr_en, grant_count,
                     e.v, e.t0, e.t1, e.d0, e.d1, e.we, e.cnt);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        nvec++;
        nmis++;
        $display("FAIL cdb_missing cyc=%0d: got no broadcast expected tag0=%0d tag1=%0d",
                 cyc, e.t0, e.t1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_grant_count", 64'(grant_count), 64'h0);
    chk("rst_fu_ready", 64'(fu_ready), 64'hF);
    reset = 1'b1;

    // Reset mid-operation with req1 and req3 held
    present(1, 6'd9, 32'h0000_0009, 1'b1);
    push(cyc + 2, 2'b01, 6'd9, 6'd0, 32'h9, 32'h0, 2'b01, 2'd1);
    step();
    idle();
    present(1, 6'd10, 32'h0000_000A, 1'b1);
    present(3, 6'd8, 32'h0000_0008, 1'b1);
    step();
    idle();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("async_rst_grant_count", 64'(grant_count), 64'h0);
    chk("async_rst_fu_ready", 64'(fu_ready), 64'hF);
    chk("async_rst_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    step();
    chk("post_rst_fu_ready", 64'(fu_ready), 64'hF);

    // Single request on req2
    present(2, 6'd5, 32'h0000_DEAD, 1'b1);
    push(cyc + 2, 2'b01, 6'd5, 6'd0, 32'hDEAD, 32'h0, 2'b01, 2'd1);
    step();
    idle();
    repeat (3) step();
    chk("single_rr_ptr", 64'(dut.rr_ptr_q), 64'h3);

    // Full contention from rr_ptr 0
    do_reset();
    present(0, 6'd1, 32'h101, 1'b1);
    present(1, 6'd2, 32'h102, 1'b0);
    present(2, 6'd3, 32'h103, 1'b1);
    present(3, 6'd4, 32'h104, 1'b0);
    push(cyc + 2, 2'b11, 6'd1, 6'd2, 32'h101, 32'h102, 2'b01, 2'd2);
    push(cyc + 3, 2'b11, 6'd3, 6'd4, 32'h103, 32'h104, 2'b01, 2'd2);
    step();
    idle();
    chk("contend_fu_ready", 64'(fu_ready), 64'h3);
    repeat (3) step();
    chk("contend_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

    // req0 streams while req1..3 wait their turn
    do_reset();
    for (int i = 0; i < 4; i++) begin
      present(i, 6'(11 + i), 32'(32'h200 + 11 + i), 1'b1);
    end
    push(cyc + 2, 2'b11, 6'd11, 6'd12, 32'h20B, 32'h20C, 2'b11, 2'd2);
    push(cyc + 3, 2'b11, 6'd13, 6'd14, 32'h20D, 32'h20E, 2'b11, 2'd2);
    push(cyc + 4, 2'b01, 6'd21, 6'd0, 32'h215, 32'h0, 2'b01, 2'd1);
    push(cyc + 5, 2'b01, 6'd22, 6'd0, 32'h216, 32'h0, 2'b01, 2'd1);
    push(cyc + 6, 2'b01, 6'd23, 6'd0, 32'h217, 32'h0, 2'b01, 2'd1);
    step();
    idle();
    chk("starve_ready_t1", 64'(fu_ready), 64'h3);
    present(0, 6'd21, 32'h215, 1'b1);
    step();
    chk("starve_ready_t2", 64'(fu_ready), 64'hE);
    present(0, 6'd22, 32'h216, 1'b1);
    step();
    chk("starve_ready_t3", 64'(fu_ready), 64'hF);
    step();
    present(0, 6'd23, 32'h217, 1'b1);
    step();
    idle();
    repeat (3) step();

    // Flush with three entries held and a new req3 result
    do_reset();
    present(0, 6'd41, 32'h41, 1'b1);
    present(1, 6'd42, 32'h42, 1'b1);
    present(2, 6'd43, 32'h43, 1'b1);
    step();
    idle();
    present(3, 6'd44, 32'h44, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("flush_grant_count", 64'(grant_count), 64'h0);
    chk("flush_fu_ready", 64'(fu_ready), 64'hF);
    chk("flush_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    present(3, 6'd45, 32'h45, 1'b0);
    push(cyc + 2, 2'b01, 6'd45, 6'd0, 32'h45, 32'h0, 2'b00, 2'd1);
    step();
    idle();
    repeat (3) step();
    chk("post_flush_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

    // Tag zero is never captured
    present(1, 6'd0, 32'hBAD0, 1'b1);
    step();
    idle();
    chk("tag0_fu_ready", 64'(fu_ready), 64'hF);
    repeat (3) step();
    chk("tag0_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

    repeat (2) step();
    chk("scoreboard_drain", 64'(q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
